// File: rtl/esc_ping_scheduler.sv
// Round-robin ping scheduler for escalation sender/receiver lanes.
// Define ESC_PING_SPURIOUS_CHK_EN to flag acks arriving on lanes that were not pinged.
module esc_ping_scheduler #(
    parameter int N_ESC  = 4,
    parameter int WAIT_W = 16,
    parameter int TO_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [N_ESC-1:0]  esc_mask_i,
    input  logic [WAIT_W-1:0] wait_cyc_i,
    input  logic [TO_W-1:0]   timeout_cyc_i,
    input  logic [N_ESC-1:0]  ping_ok_i,
    output logic [N_ESC-1:0]  ping_en_o,
    output logic [N_ESC-1:0]  ping_fail_o,
    output logic              busy_o
);

    localparam int IDX_W = (N_ESC > 1) ? $clog2(N_ESC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PING,
        GAP
    } state_e;

    state_e            state, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [IDX_W-1:0]  sel_idx, last_idx, pick_idx, sel_next;
    logic [N_ESC-1:0]  ping_en_d, fail_d;
    logic              busy_d;
    logic              do_pick, ping_exit, have_lane;

    // First masked lane strictly after last, wrapping; returns last if none is set.
    function automatic logic [IDX_W-1:0] pick(input logic [N_ESC-1:0] mask,
                                              input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        idx   = last;
        res   = last;
        found = 1'b0;
        for (int i = 0; i < N_ESC; i++) begin
            idx = (idx == IDX_W'(N_ESC - 1)) ? '0 : idx + 1'b1;
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [N_ESC-1:0] lane_bit(input logic [IDX_W-1:0] idx);
        logic [N_ESC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign have_lane = en_i && (|esc_mask_i);
    assign pick_idx  = pick(esc_mask_i, last_idx);
    assign do_pick   = (state == WAIT) && (state_d == PING);
    assign ping_exit = (state == PING) && (state_d == GAP);
    assign sel_next  = do_pick ? pick_idx : sel_idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (have_lane) state_d = WAIT;
            WAIT: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (wait_cnt <= WAIT_W'(1)) begin
                    state_d = (|esc_mask_i) ? PING : IDLE;
                end
            end
            PING: if (ping_ok_i[sel_idx] || (to_cnt <= TO_W'(1))) state_d = GAP;
            GAP:  state_d = have_lane ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered, so nothing leaks combinationally.
    always_comb begin
        ping_en_d = (state_d == PING) ? lane_bit(sel_next) : '0;
        busy_d    = (state_d != IDLE);
        fail_d    = '0;
        if (ping_exit && !ping_ok_i[sel_idx]) begin
            fail_d = lane_bit(sel_idx);
        end
`ifdef ESC_PING_SPURIOUS_CHK_EN
        fail_d = fail_d | (ping_ok_i & ~ping_en_o);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt    <= '0;
            to_cnt      <= '0;
            sel_idx     <= '0;
            last_idx    <= IDX_W'(N_ESC - 1);
            ping_en_o   <= '0;
            ping_fail_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            if ((state_d == WAIT) && (state != WAIT)) begin
                wait_cnt <= (wait_cyc_i == '0) ? WAIT_W'(1) : wait_cyc_i;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (do_pick) begin
                to_cnt  <= (timeout_cyc_i == '0) ? TO_W'(1) : timeout_cyc_i;
                sel_idx <= pick_idx;
            end else if ((state == PING) && (to_cnt != '0)) begin
                to_cnt <= to_cnt - 1'b1;
            end
            if (ping_exit) begin
                last_idx <= sel_idx;
            end
            ping_en_o   <= ping_en_d;
            ping_fail_o <= fail_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_esc_ping_scheduler.sv
// Directed self-checking bench for esc_ping_scheduler; inputs change 1 time unit after
// each rising edge and outputs are sampled at the same point.
module tb_esc_ping_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  mask = '0;
    logic [15:0] wait_cyc = '0;
    logic [7:0]  to_cyc = '0;
    logic [3:0]  ok = '0;
    logic [3:0]  ping_en;
    logic [3:0]  fail;
    logic        busy;

    int tests_run = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    esc_ping_scheduler #(
        .N_ESC (4),
        .WAIT_W(16),
        .TO_W  (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .esc_mask_i   (mask),
        .wait_cyc_i   (wait_cyc),
        .timeout_cyc_i(to_cyc),
        .ping_ok_i    (ok),
        .ping_en_o    (ping_en),
        .ping_fail_o  (fail),
        .busy_o       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_en,
                               input logic [3:0] exp_fail, input logic exp_busy);
        tests_run++;
        assert (ping_en === exp_en) else begin
            fail_cnt++;
            $error("[TB] FAIL %s ping_en observed=%b expected=%b", tag, ping_en, exp_en);
        end
        tests_run++;
        assert (fail === exp_fail) else begin
            fail_cnt++;
            $error("[TB] FAIL %s ping_fail observed=%b expected=%b", tag, fail, exp_fail);
        end
        tests_run++;
        assert (busy === exp_busy) else begin
            fail_cnt++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, exp_busy);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] m,
                                 input logic [15:0] w, input logic [7:0] t);
        en       = e;
        mask     = m;
        wait_cyc = w;
        to_cyc   = t;
        ok       = '0;
    endtask

    // Reset takes effect at once; the first active edge follows the release.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput(tag, 4'b0000, 4'b0000, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic waitPhase(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput(tag, 4'b0000, 4'b0000, 1'b1);
        end
    endtask

    // Ping held for 'high' cycles; ack (if any) given in the last one, then the Gap cycle.
    task automatic pingPhase(input string tag, input logic [3:0] lane,
                             input int high, input bit ack);
        for (int k = 1; k <= high; k++) begin
            tick();
            checkOutput(tag, lane, 4'b0000, 1'b1);
            if (ack && k == high) ok = lane;
        end
        tick();
        ok = '0;
        checkOutput({tag, "_gap"}, 4'b0000, ack ? 4'b0000 : lane, 1'b1);
    endtask

    initial begin
        logic [3:0] rot [5];
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // full rotation with acks two cycles after each ping rises
        applyStimulus(1'b1, 4'b1111, 16'd3, 8'd5);
        tick();
        checkOutput("reset", 4'b0000, 4'b0000, 1'b0);
        doReset("reset_async");
        for (int i = 0; i < 5; i++) begin
            waitPhase("rot_wait", 3);
            pingPhase("rot_ping", rot[i], 3, 1'b1);
        end

        // lane 2 never acks and times out after 4 cycles
        applyStimulus(1'b1, 4'b0101, 16'd3, 8'd4);
        doReset("to_reset");
        waitPhase("to_wait0", 3);
        pingPhase("to_lane0", 4'b0001, 3, 1'b1);
        waitPhase("to_wait2", 3);
        pingPhase("to_lane2", 4'b0100, 4, 1'b0);
        waitPhase("to_after", 3);
        tick();
        checkOutput("to_back0", 4'b0001, 4'b0000, 1'b1);

        // enable dropped during a ping: ping completes, then Idle
        applyStimulus(1'b1, 4'b1111, 16'd3, 8'd8);
        doReset("en_reset");
        waitPhase("en_wait", 3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput("en_hold", 4'b0001, 4'b0000, 1'b1);
            if (k == 2) en = 1'b0;
            if (k == 5) ok = 4'b0001;
        end
        tick();
        ok = '0;
        checkOutput("en_gap", 4'b0000, 4'b0000, 1'b1);
        tick();
        checkOutput("en_idle", 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("en_idle2", 4'b0000, 4'b0000, 1'b0);

        // zero wait and zero timeout behave as one
        applyStimulus(1'b1, 4'b0001, 16'd0, 8'd0);
        doReset("zero_reset");
        waitPhase("zero_wait", 1);
        pingPhase("zero_ping", 4'b0001, 1, 1'b0);
        waitPhase("zero_wait2", 1);
        pingPhase("zero_ping2", 4'b0001, 1, 1'b0);

        // ack on the last timeout cycle is a success; then reset mid-ping
        applyStimulus(1'b1, 4'b1111, 16'd3, 8'd3);
        doReset("last_reset");
        waitPhase("last_wait", 3);
        pingPhase("last_ok", 4'b0001, 3, 1'b1);
        waitPhase("last_wait1", 3);
        tick();
        checkOutput("mid_ping", 4'b0010, 4'b0000, 1'b1);
        tick();
        checkOutput("mid_ping2", 4'b0010, 4'b0000, 1'b1);
        doReset("mid_reset");
        waitPhase("mid_wait", 3);
        tick();
        checkOutput("mid_lane0", 4'b0001, 4'b0000, 1'b1);

        // spurious ack on an idle lane during Wait
        applyStimulus(1'b1, 4'b1111, 16'd3, 8'd5);
        doReset("sp_reset");
        tick();
        checkOutput("sp_wait1", 4'b0000, 4'b0000, 1'b1);
        ok = 4'b1000;
        tick();
        ok = '0;
`ifdef ESC_PING_SPURIOUS_CHK_EN
        checkOutput("sp_flag", 4'b0000, 4'b1000, 1'b1);
`else
        checkOutput("sp_flag", 4'b0000, 4'b0000, 1'b1);
`endif
        tick();
        checkOutput("sp_wait3", 4'b0000, 4'b0000, 1'b1);
        pingPhase("sp_ping", 4'b0001, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/esc_ping_scheduler.md
# esc_ping_scheduler

Round-robin ping controller for a bank of escalation sender/receiver pairs. Periodically selects one enabled escalation lane, raises its ping request, holds it until the lane returns ping-ok or a timeout expires, and flags lanes that fail to answer. Sits between the alert/escalation configuration registers and the `ping_en`/`ping_ok` ports of the escalation senders. It guarantees the sender ping contract: ping stays high until ok, then drops for at least one cycle.

## Interface
- `N_ESC`, default 4: number of escalation lanes, 1..8.
- `WAIT_W`, default 16: width of the inter-ping wait counter.
- `TO_W`, default 8: width of the ping timeout counter.
- `clk_i  in  1`: clock.
- `rst_ni  in  1`: reset. Asynchronous, active-low; the only reset.
- `en_i  in  1`: enables ping scheduling.
- `esc_mask_i  in  N_ESC`: lanes taking part in the rotation. A 1 means pinged.
- `wait_cyc_i  in  WAIT_W`: idle cycles between pings. 0 is treated as 1.
- `timeout_cyc_i  in  TO_W`: maximum cycles `ping_en_o` stays high without ok. 0 is treated as 1.
- `ping_ok_i  in  N_ESC`: ping acknowledge from each sender.
- `ping_en_o  out  N_ESC`: ping request to each sender. At most one bit is high.
- `ping_fail_o  out  N_ESC`: one-cycle pulse per lane on a ping failure.
- `busy_o  out  1`: high in every state except Idle.

## Operation
- FSM states and transitions:
  - Idle → Wait when `en_i && |esc_mask_i`. On entry to Wait, load the wait counter with `max(wait_cyc_i,1)`.
  - Wait: decrement the counter each cycle. On the cycle it reads 1:
    - Pick the next lane with its mask bit set, searching upward (modulo `N_ESC`) from `last_idx+1`.
    - Register the pick as `sel_idx`.
    - Load the timeout counter with `max(timeout_cyc_i,1)`.
    - Go to Ping.
    - If the mask is now all-zero, go to Idle instead.
  - Ping: `ping_en_o[sel_idx]` = 1 and the timeout counter decrements.
    - `ping_ok_i[sel_idx]` seen → Gap.
    - Counter reads 1 with no ok → Gap, with `ping_fail_o[sel_idx]` pulsed in the Gap cycle.
    - `last_idx` ← `sel_idx` on either exit.
  - Gap: exactly one cycle with all `ping_en_o` low. Then go to Wait if `en_i && |esc_mask_i`, else Idle.
- `ping_ok_i` on non-selected lanes is ignored (see Configuration).
- `en_i` deasserted during Ping: the ping is not aborted. It completes via ok or timeout, and Gap then exits to Idle. `en_i` deasserted in Wait → Idle next cycle.
- Mask changes during Ping do not affect `sel_idx`. They take effect at the next selection.
- `wait_cyc_i` and `timeout_cyc_i` are sampled only when the corresponding counter is loaded.
- Counters saturate at 0 and never wrap. A `last_idx` wrap from `N_ESC-1` goes to 0.

## Timing
- Reset values:
  - state = Idle.
  - `ping_en_o` = 0, `ping_fail_o` = 0, `busy_o` = 0.
  - `last_idx` = `N_ESC-1`, so lane 0 is pinged first.
- All outputs are registered. There are no combinational input-to-output paths.
- Idle→Wait takes 1 cycle after `en_i` rises. Wait lasts W = `max(wait_cyc_i,1)` cycles. `ping_en_o` rises in the cycle after the last Wait cycle.
- Ok sampled in Ping cycle k → `ping_en_o` low in cycle k+1 (Gap). An ok in the same cycle as the last timeout cycle counts as success; no fail is raised.
- Timeout T: `ping_en_o` is high for exactly T cycles. `ping_fail_o` pulses in the next cycle, coincident with `ping_en_o` low.
- Asynchronous reset mid-Ping drops `ping_en_o` immediately. No fail is raised.

## Configuration
- `ESC_PING_SPURIOUS_CHK_EN` defined:
  - In any state, `ping_ok_i[j]` high for a lane j with `ping_en_o[j]` low pulses `ping_fail_o[j]` in the next cycle.
  - This does not change FSM state.
  - Pulses OR together with timeout fails.
- Not defined: spurious acks are ignored and the check logic is absent.

## Test plan
- Reset with `en_i`=1, mask=4'b1111, wait=3, timeout=5, each ok returned 2 cycles after ping rises → `ping_en_o` goes 0001, 0010, 0100, 1000, 0001. Each ping is high 3 cycles, separated by a 1-cycle Gap plus 3 Wait cycles. No fails.
- Mask=4'b0101, lane 2 never acks, timeout=4 → lane 0 ok. Lane 2 `ping_en_o` is high exactly 4 cycles, then `ping_fail_o`=4'b0100 for one cycle. Rotation returns to lane 0.
- `en_i` dropped on the second cycle of a ping (timeout=8), with ok on cycle 5 → ping held until the ok, 1-cycle Gap, then Idle with `busy_o`=0. No new ping.
- `wait_cyc_i`=0 and `timeout_cyc_i`=0, with a lane that never acks → 1 Wait cycle, ping high 1 cycle, fail pulse. No hang, no counter wrap.
- Ok arrives in the last timeout cycle (timeout=3, ok on cycle 3) → success, no fail. Separately, assert `rst_ni`=0 mid-Ping → `ping_en_o`=0 immediately, state Idle, next ping goes to lane 0.
- With `ESC_PING_SPURIOUS_CHK_EN`, pulse `ping_ok_i`=4'b1000 during Wait → `ping_fail_o`=4'b1000 for one cycle and the schedule is unchanged. Without the macro → no fail.
